apb_master_fsm: RTL and testbench

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

---
 rtl/apb_master_fsm.sv | 154 +++++++++++++++
 tb/tb_apb_master_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// APB master: turns a valid/ready request stream into APB SETUP/ACCESS transfers
// over three decoded peripheral windows and returns a one-cycle response pulse.
module apb_master_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic [2:0]        pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              accept_s;
    logic [2:0]        dec_s;

    // Three 64 MiB windows starting at 0x8000_0000; anything else is a decode failure.
    function automatic logic [2:0] addr_decode(input logic [ADDR_W-1:0] addr);
        logic [63:0] a;
        a = 64'(addr);
        if (a >= 64'h0000_0000_8000_0000 && a < 64'h0000_0000_8400_0000) begin
            addr_decode = 3'b001;
        end else if (a >= 64'h0000_0000_8400_0000 && a < 64'h0000_0000_8800_0000) begin
            addr_decode = 3'b010;
        end else if (a >= 64'h0000_0000_8800_0000 && a < 64'h0000_0000_8C00_0000) begin
            addr_decode = 3'b100;
        end else begin
            addr_decode = 3'b000;
        end
    endfunction

    assign req_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCESS);
    assign accept_s   = req_valid && req_ready;
    assign dec_s      = addr_decode(req_addr);

    assign pselx      = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign rd_data    = rd_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = 1'b0;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rd_data_d    = rd_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCESS: begin
                if (state_q == ST_ACCESS) begin
                    resp_valid_d = 1'b1;
                    if (!pwrite_q) begin
                        rd_data_d = prdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    resp_valid_d = 1'b0;
                end
                // A new request can chain directly off the end of ACCESS.
                if (accept_s) begin
                    if (dec_s != 3'b000) begin
                        state_d  = ST_SETUP;
                        psel_d   = dec_s;
                        pwrite_d = req_write;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                    end else begin
                        state_d = ST_ERR;
                        psel_d  = 3'b000;
                    end
                end else begin
                    state_d = ST_IDLE;
                    psel_d  = 3'b000;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ERR: begin
                state_d      = ST_IDLE;
                psel_d       = 3'b000;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                psel_d  = 3'b000;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            psel_q       <= 3'b000;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= {ADDR_W{1'b0}};
            pwdata_q     <= {DATA_W{1'b0}};
            rd_data_q    <= {DATA_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rd_data_q    <= rd_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: directed opening sequence then random traffic, checked
// against a cycle-schedule model of each accepted request.
module tb_apb_master_fsm;

    localparam int NCYC = 1500;
    localparam int NARR = NCYC + 8;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [31:0] rd_data;
    logic        resp_valid;
    logic        resp_err;

    apb_master_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .rd_data    (rd_data),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle outputs, filled forward when a request is accepted.
    logic [2:0]  e_psel   [NARR];
    bit          e_pen    [NARR];
    bit          e_rv     [NARR];
    bit          e_re     [NARR];
    bit          cap_at   [NARR];
    logic [31:0] cap_addr [NARR];
    logic [31:0] cap_wdata[NARR];
    bit          cap_write[NARR];
    bit          rd_at    [NARR];
    logic [31:0] pr_hist  [NARR];
    logic [31:0] m_addr, m_wdata, m_rd;
    bit          m_write;
    int          busy_until;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".pselx"}, 64'(pselx), 64'd0);
        check_val({tag, ".penable"}, 64'(penable), 64'd0);
        check_val({tag, ".pwrite"}, 64'(pwrite), 64'd0);
        check_val({tag, ".paddr"}, 64'(paddr), 64'd0);
        check_val({tag, ".pwdata"}, 64'(pwdata), 64'd0);
        check_val({tag, ".rd_data"}, 64'(rd_data), 64'd0);
        check_val({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
        check_val({tag, ".resp_err"}, 64'(resp_err), 64'd0);
        check_val({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic clear_model(input int from);
        for (int i = from; i < NARR; i++) begin
            e_psel[i] = 3'b000; e_pen[i] = 1'b0; e_rv[i] = 1'b0; e_re[i] = 1'b0;
            cap_at[i] = 1'b0; rd_at[i] = 1'b0;
            cap_addr[i] = 32'd0; cap_wdata[i] = 32'd0; cap_write[i] = 1'b0;
        end
        m_addr = 32'd0; m_wdata = 32'd0; m_rd = 32'd0; m_write = 1'b0;
    endtask

    function automatic logic [2:0] ref_decode(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8C00_0000) begin
            ref_decode = 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
        end else begin
            ref_decode = 3'b000;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [8];
        edges = '{32'h8000_0000, 32'h83FF_FFFC, 32'h8400_0000, 32'h87FF_FFFF,
                  32'h8800_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
        case ($urandom_range(0, 4))
            0: rand_addr = edges[$urandom_range(0, 7)];
            1: rand_addr = 32'h8000_0000 + ($urandom & 32'h03FF_FFFC);
            2: rand_addr = 32'h8400_0000 + ($urandom & 32'h03FF_FFFC);
            3: rand_addr = 32'h8800_0000 + ($urandom & 32'h03FF_FFFC);
            default: rand_addr = $urandom;
        endcase
    endfunction

    initial begin
        bit v, w, rst;
        logic [31:0] a, d, pr;
        logic [2:0] dec;

        hresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; prdata = 32'd0;
        clear_model(0);
        for (int i = 0; i < NARR; i++) pr_hist[i] = 32'd0;
        #7;
        check_reset_outputs("por");
        #5 hresetn = 1'b1;
        busy_until = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge hclk);
            #1;
            if (cap_at[c]) begin
                m_addr = cap_addr[c]; m_wdata = cap_wdata[c]; m_write = cap_write[c];
            end
            if (rd_at[c]) m_rd = pr_hist[c-1];
            check_val("req_ready", 64'(req_ready), 64'(c >= busy_until));
            check_val("pselx", 64'(pselx), 64'(e_psel[c]));
            check_val("penable", 64'(penable), 64'(e_pen[c]));
            check_val("resp_valid", 64'(resp_valid), 64'(e_rv[c]));
            check_val("resp_err", 64'(resp_err), 64'(e_re[c]));
            check_val("paddr", 64'(paddr), 64'(m_addr));
            check_val("pwrite", 64'(pwrite), 64'(m_write));
            check_val("pwdata", 64'(pwdata), 64'(m_wdata));
            check_val("rd_data", 64'(rd_data), 64'(m_rd));

            v = 1'b0; w = 1'b0; a = 32'd0; d = 32'hA5A5_0000 + 32'(c);
            pr = 32'h5A5A_0000 + 32'(c); rst = 1'b0;
            if (c < 24) begin
                case (c)
                    0:  begin v = 1'b1; w = 1'b1; a = 32'h8000_0010; d = 32'hDEAD_BEEF; end
                    4:  begin v = 1'b1; w = 1'b0; a = 32'h8400_0004; end
                    6:  pr = 32'h1234_5678;
                    8:  begin v = 1'b1; w = 1'b1; a = 32'h8800_0000; d = 32'h1111_1111; end
                    9:  begin v = 1'b1; w = 1'b1; a = 32'h8000_0040; d = 32'h2222_2222; end
                    10: begin v = 1'b1; w = 1'b0; a = 32'h8000_0000; d = 32'h3333_3333; end
                    14: begin v = 1'b1; w = 1'b0; a = 32'h9000_0000; end
                    17: begin v = 1'b1; w = 1'b1; a = 32'h8000_0020; d = 32'hCAFE_F00D; end
                    19: rst = 1'b1;
                    20: begin v = 1'b1; w = 1'b0; a = 32'h8000_0000; end
                    default: v = 1'b0;
                endcase
            end else begin
                v = ($urandom_range(0, 99) < 65);
                w = 1'(($urandom_range(0, 1)));
                a = rand_addr();
                d = $urandom;
                pr = $urandom;
                rst = ($urandom_range(0, 199) == 0);
            end
            if (rst) v = 1'b0;

            req_valid = v; req_write = w; req_addr = a; req_wdata = d; prdata = pr;
            pr_hist[c] = pr;

            if (rst) begin
                #2 hresetn = 1'b0;
                #1 check_reset_outputs("midrst");
                clear_model(c + 1);
                busy_until = c;
                #2 hresetn = 1'b1;
                #1 check_val("ready_after_rst", 64'(req_ready), 64'd1);
            end else if (v && c >= busy_until) begin
                dec = ref_decode(a);
                if (dec != 3'b000) begin
                    e_psel[c+1] = dec; e_pen[c+1] = 1'b0;
                    e_psel[c+2] = dec; e_pen[c+2] = 1'b1;
                    e_rv[c+3] = 1'b1;
                    cap_at[c+1] = 1'b1; cap_addr[c+1] = a; cap_wdata[c+1] = d; cap_write[c+1] = w;
                    rd_at[c+3] = !w;
                end else begin
                    e_rv[c+2] = 1'b1; e_re[c+2] = 1'b1;
                end
                busy_until = c + 2;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
